// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (F) and data (M).
// M has priority; F is forced through after STARVE_MAX consecutive losses.
// Optional watchdog on hung memory transactions: define MEM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 80,
  parameter int unsigned STARVE_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT  = 15
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_valid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  output logic              f_stall_o,
  input  logic              m_req_i,
  input  logic              m_we_i,
  input  logic [ADDR_W-1:0] m_addr_i,
  input  logic [DATA_W-1:0] m_wdata_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_rdata_o,
  output logic              m_err_o,
  output logic              m_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_err_i
);

  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_M, RESP} state_t;

  state_t            state, state_nx;
  logic [SC_W-1:0]   starve_cnt, starve_nx;
  logic              squash, squash_nx;
  logic              mem_req_nx, mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx;
  logic              f_valid_nx, m_valid_nx, m_err_nx;
  logic [DATA_W-1:0] f_rdata_nx, m_rdata_nx;
  logic              grant_f, req_live, done, done_err;
  logic [DATA_W-1:0] done_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WC_W = $clog2(TIMEOUT + 1);
  logic [WC_W-1:0] wait_cnt;

  // Watchdog: counts cycles spent waiting on the memory slave.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (state == BUSY_F || state == BUSY_M) begin
      wait_cnt <= wait_cnt + WC_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  // Stall requests to the hazard controller.
  assign f_stall_o = f_req_i & ~f_valid_o;
  assign m_stall_o = m_req_i & ~m_valid_o;

  // State, starvation counter and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      squash      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      f_valid_o   <= 1'b0;
      m_valid_o   <= 1'b0;
      m_err_o     <= 1'b0;
      f_rdata_o   <= '0;
      m_rdata_o   <= '0;
    end else begin
      state       <= state_nx;
      starve_cnt  <= starve_nx;
      squash      <= squash_nx;
      mem_req_o   <= mem_req_nx;
      mem_we_o    <= mem_we_nx;
      mem_addr_o  <= mem_addr_nx;
      mem_wdata_o <= mem_wdata_nx;
      f_valid_o   <= f_valid_nx;
      m_valid_o   <= m_valid_nx;
      m_err_o     <= m_err_nx;
      f_rdata_o   <= f_rdata_nx;
      m_rdata_o   <= m_rdata_nx;
    end
  end

  // Next-state: arbitration in IDLE, completion in BUSY, one-cycle response.
  always_comb begin
    state_nx     = state;
    starve_nx    = starve_cnt;
    squash_nx    = squash;
    mem_req_nx   = mem_req_o;
    mem_we_nx    = mem_we_o;
    mem_addr_nx  = mem_addr_o;
    mem_wdata_nx = mem_wdata_o;
    f_valid_nx   = 1'b0;
    m_valid_nx   = 1'b0;
    m_err_nx     = 1'b0;
    f_rdata_nx   = f_rdata_o;
    m_rdata_nx   = m_rdata_o;
    grant_f      = 1'b0;
    req_live     = 1'b0;
    done         = 1'b0;
    done_err     = 1'b0;
    done_data    = '0;

    case (state)
      IDLE: begin
        if (f_req_i && m_req_i) begin
          grant_f = (starve_cnt == SC_W'(STARVE_MAX));
        end else begin
          grant_f = f_req_i;
        end
        if (f_req_i || m_req_i) begin
          mem_req_nx = 1'b1;
          squash_nx  = 1'b0;
          if (grant_f) begin
            state_nx     = BUSY_F;
            mem_we_nx    = 1'b0;
            mem_addr_nx  = f_addr_i;
            mem_wdata_nx = '0;
            starve_nx    = '0;
          end else begin
            state_nx     = BUSY_M;
            mem_we_nx    = m_we_i;
            mem_addr_nx  = m_addr_i;
            mem_wdata_nx = m_wdata_i;
            if (f_req_i && starve_cnt != SC_W'(STARVE_MAX)) begin
              starve_nx = starve_cnt + SC_W'(1);
            end
          end
        end
      end

      BUSY_F, BUSY_M: begin
        // A requester that lets go of its request loses the response.
        req_live  = (state == BUSY_F) ? f_req_i : m_req_i;
        squash_nx = squash | ~req_live;
        if (mem_ack_i) begin
          done      = 1'b1;
          done_err  = mem_err_i;
          done_data = mem_rdata_i;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
`endif
        if (done) begin
          state_nx   = RESP;
          mem_req_nx = 1'b0;
          if (state == BUSY_F) begin
            f_valid_nx = ~squash_nx;
            f_rdata_nx = done_err ? '0 : done_data;
          end else begin
            m_valid_nx = ~squash_nx;
            m_err_nx   = done_err & ~squash_nx;
            m_rdata_nx = (mem_we_o | done_err) ? '0 : done_data;
          end
        end
      end

      RESP: state_nx = IDLE;

      default: state_nx = IDLE;
    endcase
  end

endmodule
